fast_spi_tx: RTL and testbench
==============================

Name: fast_spi_tx

Overview:
- Transmit counterpart of fast_spi_rx.
- Pops 32-bit words from an upstream first-word-fall-through FIFO and shifts them out serially, one bit per BUS_CLK cycle, for a programmed number of bits.
- Drives SDO, SEN and SCLK_EN. SCLK_EN feeds the output DDR clock gate, so SCLK toggles only while bits are valid.
- Configured through the standard 8-bit basil register bus; sits beside the seq_gen and fast_spi_rx instances in the top level.

Parameters:
- BASEADDR, 32'h0000, first bus address of the block.
- HIGHADDR, 32'h000f, last bus address of the block.
- ABUSWIDTH, 32, width of BUS_ADD.

Ports:
- BUS_CLK  in  1  single clock for bus and shifter.
- RSTn  in  1  asynchronous active-low reset.
- BUS_ADD  in  ABUSWIDTH  bus address.
- BUS_DATA  inout  8  bus data.
- BUS_RD  in  1  bus read strobe.
- BUS_WR  in  1  bus write strobe.
- FIFO_DATA  in  32  head word of the upstream FIFO; valid while FIFO_EMPTY=0.
- FIFO_EMPTY  in  1  upstream FIFO empty.
- FIFO_READ  out  1  one-cycle pop of the head word.
- SDO  out  1  serial data.
- SEN  out  1  high while SDO holds a valid bit.
- SCLK_EN  out  1  equals SEN; gates the external DDR clock.

Behaviour:
- Register map, offsets from BASEADDR:
  - 0: write = soft reset, same effect as RSTn. Read = version 8'd1.
  - 1: CTRL/STATUS.
    - Write bit0 = START, one-shot.
    - Read bit0 = DONE, bit1 = BUSY, bit3 = UNDERFLOW (sticky).
  - 2 and 3: BIT_CNT[7:0] and BIT_CNT[15:8], read/write.
  - 4 and 5: WORDS_POPPED[15:0], read-only.
  - Offsets 6–15 read 0; writes to them are ignored.
- Bus reads: read address is registered on BUS_RD. BUS_DATA is driven in the following cycle only, and is Z otherwise.
- Reset (RSTn low or soft reset):
  - FIFO_READ=0, SDO=0, SEN=0, SCLK_EN=0, state IDLE.
  - DONE=0, UNDERFLOW=0, BIT_CNT=0, WORDS_POPPED=0.
- State machine: IDLE, LOAD, SHIFT, STALL, FINISH.
  - IDLE: a START write in cycle N clears DONE, UNDERFLOW and WORDS_POPPED, loads the remaining-bit counter from BIT_CNT, and moves to LOAD at N+1.
  - IDLE with BIT_CNT=0: START goes straight to FINISH; no bit is sent and no pop occurs.
  - LOAD:
    - If FIFO_EMPTY=0: capture FIFO_DATA into a shift register, pulse FIFO_READ for 1 cycle, increment WORDS_POPPED, and go to SHIFT.
    - If FIFO_EMPTY=1: set UNDERFLOW, go to STALL.
  - SHIFT:
    - Each cycle: SEN=SCLK_EN=1, SDO = shift register MSB (bit 31 first), shift left, decrement the remaining counter.
    - After the 32nd bit of a word with remaining>0, go to LOAD. This inserts exactly one SEN-low gap cycle between words.
    - When remaining reaches 0, go to FINISH. Unsent bits of the last word are discarded; that word is already popped.
  - STALL: SEN=0. Return to LOAD in the cycle after FIFO_EMPTY falls.
  - FINISH: set DONE, go to IDLE.
- BUSY = (state != IDLE).
- Latency: START written at cycle N with a non-empty FIFO gives FIFO_READ at N+1 and the first SEN=1 at N+2.
- Counter widths:
  - Remaining-bit counter is 16 bits; BIT_CNT maximum is 65535.
  - WORDS_POPPED saturates at 16'hffff.
- Simultaneous events and edge cases:
  - START while BUSY is ignored.
  - BIT_CNT writes while BUSY take effect at the next START.
  - Soft reset mid-transfer aborts within 1 cycle: SEN drops and no further pops occur.
  - RSTn low mid-transfer forces all outputs low immediately (asynchronous).
- SDO is 0 whenever SEN=0.

Optional Feature:
- Macro: FAST_SPI_TX_LSB_FIRST_EN.
- Defined: CTRL bit2 is a read/write register, reset 0. When set, each word is shifted LSB first (bit 0 first, shift right). The value is sampled at START.
- Undefined: CTRL bit2 reads 0 and writes to it are ignored; MSB-first only.

Test Plan:
- FIFO holds 32'hA5A5_0F0F, BIT_CNT=32, START:
  - FIFO_READ pulses once at N+1.
  - SEN is high for exactly 32 cycles from N+2.
  - SDO sequence is 1010_0101_1010_0101_0000_1111_0000_1111.
  - DONE=1; WORDS_POPPED=1.
- FIFO holds 32'hFFFF_FFFF then 32'h0000_0001, BIT_CNT=40:
  - 32 ones, 1-cycle SEN gap, then 8 zeros.
  - 2 pops; the remaining 24 bits of word 2 are discarded.
- Empty FIFO, BIT_CNT=8, START:
  - UNDERFLOW=1, BUSY=1, SEN stays 0.
  - Push 32'h8000_0000 after 10 cycles: SDO=1 then 7 zeros, then DONE.
- BIT_CNT=0, START:
  - DONE set within 2 cycles, FIFO_READ never asserted, SEN never high.
- Mid-transfer at bit 10 of 32:
  - Soft reset write, then RSTn low in a second run: SEN=0 within 1 cycle.
  - Status reads 0; a second START still behaves as in the first scenario.
- With FAST_SPI_TX_LSB_FIRST_EN defined, CTRL bit2=1, word 32'h0000_0003, BIT_CNT=4:
  - SDO = 1,1,0,0.
  - Without the macro, CTRL bit2 reads 0 and SDO = 0,0,0,0.

Source files
------------

// File: rtl/fast_spi_tx_if.sv
// Bus, FIFO and serial-output bundle for fast_spi_tx.
// FIFO handshake: FIFO_EMPTY=0 means FIFO_DATA is valid; FIFO_READ=1 pops that word at the clock edge ending the cycle.
interface fast_spi_tx_if #(
   parameter int ABUSWIDTH = 32
);
   logic [ABUSWIDTH-1:0] BUS_ADD;
   logic                 BUS_RD;
   logic                 BUS_WR;
   logic [31:0]          FIFO_DATA;
   logic                 FIFO_EMPTY;
   logic                 FIFO_READ;
   logic                 SDO;
   logic                 SEN;
   logic                 SCLK_EN;
   logic [2:0]           state_dbg;

   modport master (
      output BUS_ADD, BUS_RD, BUS_WR, FIFO_DATA, FIFO_EMPTY,
      input  FIFO_READ, SDO, SEN, SCLK_EN, state_dbg
   );

   modport slave (
      input  BUS_ADD, BUS_RD, BUS_WR, FIFO_DATA, FIFO_EMPTY,
      output FIFO_READ, SDO, SEN, SCLK_EN, state_dbg
   );
endinterface

// File: rtl/fast_spi_tx.sv
// Serial transmitter: pops 32-bit words from a FWFT FIFO and shifts BIT_CNT bits out on SDO/SEN.
// Optional macro FAST_SPI_TX_LSB_FIRST_EN adds CTRL bit2 (LSB-first shifting).
module fast_spi_tx #(
   parameter logic [31:0] BASEADDR  = 32'h0000,
   parameter logic [31:0] HIGHADDR  = 32'h000f,
   parameter int          ABUSWIDTH = 32
) (
   input  logic         BUS_CLK,
   input  logic         RSTn,
   inout  wire  [7:0]   BUS_DATA,
   fast_spi_tx_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SHIFT  = 3'd2,
      ST_STALL  = 3'd3,
      ST_FINISH = 3'd4
   } state_t;

   // Address decode by offset; the subtraction wraps so addresses below BASEADDR fall out of range.
   localparam logic [ABUSWIDTH-1:0] BASE   = BASEADDR[ABUSWIDTH-1:0];
   localparam logic [31:0]          SPAN32 = HIGHADDR - BASEADDR;
   localparam logic [ABUSWIDTH-1:0] SPAN   = SPAN32[ABUSWIDTH-1:0];

   logic [ABUSWIDTH-1:0] addr_off;
   logic                 in_range;
   logic [3:0]           off;
   logic                 wr_hit;
   logic                 rd_hit;
   logic                 soft_rst;
   logic                 start_wr;

   assign addr_off = bus.BUS_ADD - BASE;
   assign in_range = (addr_off <= SPAN);
   assign off      = addr_off[3:0];
   assign wr_hit   = bus.BUS_WR && in_range;
   assign rd_hit   = bus.BUS_RD && in_range;
   assign soft_rst = wr_hit && (off == 4'd0);
   assign start_wr = wr_hit && (off == 4'd1) && BUS_DATA[0];

   state_t      state;
   logic [15:0] bit_cnt;
   logic [15:0] remaining;
   logic [15:0] words_popped;
   logic [31:0] shreg;
   logic [5:0]  bit_idx;
   logic        done;
   logic        underflow;
   logic        sen;
   logic        sdo;
   logic        busy;
   logic        ctrl_lsb;
   logic        lsb_run;

   assign busy          = (state != ST_IDLE);
   assign bus.FIFO_READ = (state == ST_LOAD) && !bus.FIFO_EMPTY;
   assign bus.SEN       = sen;
   assign bus.SCLK_EN   = sen;
   assign bus.SDO       = sdo;
   assign bus.state_dbg = state;

`ifdef FAST_SPI_TX_LSB_FIRST_EN
   // Shift direction is latched from the START write so a later CTRL write cannot disturb a transfer.
   always_ff @(posedge BUS_CLK or negedge RSTn) begin
      if (!RSTn) begin
         ctrl_lsb <= 1'b0;
         lsb_run  <= 1'b0;
      end else if (soft_rst) begin
         ctrl_lsb <= 1'b0;
         lsb_run  <= 1'b0;
      end else begin
         if (wr_hit && (off == 4'd1)) ctrl_lsb <= BUS_DATA[2];
         if (start_wr && (state == ST_IDLE)) lsb_run <= BUS_DATA[2];
      end
   end
`else
   assign ctrl_lsb = 1'b0;
   assign lsb_run  = 1'b0;
`endif

   always_ff @(posedge BUS_CLK or negedge RSTn) begin
      if (!RSTn) begin
         state        <= ST_IDLE;
         bit_cnt      <= 16'd0;
         remaining    <= 16'd0;
         words_popped <= 16'd0;
         shreg        <= 32'd0;
         bit_idx      <= 6'd0;
         done         <= 1'b0;
         underflow    <= 1'b0;
         sen          <= 1'b0;
         sdo          <= 1'b0;
      end else if (soft_rst) begin
         state        <= ST_IDLE;
         bit_cnt      <= 16'd0;
         remaining    <= 16'd0;
         words_popped <= 16'd0;
         shreg        <= 32'd0;
         bit_idx      <= 6'd0;
         done         <= 1'b0;
         underflow    <= 1'b0;
         sen          <= 1'b0;
         sdo          <= 1'b0;
      end else begin
         if (wr_hit && (off == 4'd2)) bit_cnt[7:0]  <= BUS_DATA;
         if (wr_hit && (off == 4'd3)) bit_cnt[15:8] <= BUS_DATA;
         case (state)
            ST_IDLE: begin
               if (start_wr) begin
                  done         <= 1'b0;
                  underflow    <= 1'b0;
                  words_popped <= 16'd0;
                  remaining    <= bit_cnt;
                  state        <= (bit_cnt == 16'd0) ? ST_FINISH : ST_LOAD;
               end
            end
            ST_LOAD: begin
               // The first bit of the word goes out on the same edge that pops it.
               if (!bus.FIFO_EMPTY) begin
                  sen       <= 1'b1;
                  sdo       <= lsb_run ? bus.FIFO_DATA[0] : bus.FIFO_DATA[31];
                  shreg     <= lsb_run ? (bus.FIFO_DATA >> 1) : (bus.FIFO_DATA << 1);
                  remaining <= remaining - 16'd1;
                  bit_idx   <= 6'd1;
                  if (words_popped != 16'hffff) words_popped <= words_popped + 16'd1;
                  state     <= ST_SHIFT;
               end else begin
                  underflow <= 1'b1;
                  state     <= ST_STALL;
               end
            end
            ST_SHIFT: begin
               if (remaining == 16'd0) begin
                  sen   <= 1'b0;
                  sdo   <= 1'b0;
                  state <= ST_FINISH;
               end else if (bit_idx == 6'd32) begin
                  sen   <= 1'b0;
                  sdo   <= 1'b0;
                  state <= ST_LOAD;
               end else begin
                  sdo       <= lsb_run ? shreg[0] : shreg[31];
                  shreg     <= lsb_run ? (shreg >> 1) : (shreg << 1);
                  remaining <= remaining - 16'd1;
                  bit_idx   <= bit_idx + 6'd1;
               end
            end
            ST_STALL: begin
               if (!bus.FIFO_EMPTY) state <= ST_LOAD;
            end
            ST_FINISH: begin
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Read data is returned in the cycle after BUS_RD; the bus is released otherwise.
   logic       rd_valid;
   logic [3:0] rd_off;
   logic [7:0] rd_data;

   always_ff @(posedge BUS_CLK or negedge RSTn) begin
      if (!RSTn) begin
         rd_valid <= 1'b0;
         rd_off   <= 4'd0;
      end else begin
         rd_valid <= rd_hit;
         if (rd_hit) rd_off <= off;
      end
   end

   always_comb begin
      rd_data = 8'd0;
      case (rd_off)
         4'd0:    rd_data = 8'd1;
         4'd1:    rd_data = {4'd0, underflow, ctrl_lsb, busy, done};
         4'd2:    rd_data = bit_cnt[7:0];
         4'd3:    rd_data = bit_cnt[15:8];
         4'd4:    rd_data = words_popped[7:0];
         4'd5:    rd_data = words_popped[15:8];
         default: rd_data = 8'd0;
      endcase
   end

   assign BUS_DATA = rd_valid ? rd_data : 8'hzz;

endmodule

// File: tb/tb_fast_spi_tx.sv
// Directed bench for fast_spi_tx: FIFO model, bus driver tasks, serial monitor and a summary report.
module tb_fast_spi_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   wire  [7:0] bus_data;
   logic [7:0] tb_wdata;
   logic       tb_drv;

   fast_spi_tx_if #(.ABUSWIDTH(32)) bif ();

   assign bus_data = tb_drv ? tb_wdata : 8'hzz;

   fast_spi_tx #(
      .BASEADDR (32'h0000),
      .HIGHADDR (32'h000f),
      .ABUSWIDTH(32)
   ) dut (
      .BUS_CLK (clk),
      .RSTn    (rst_n),
      .BUS_DATA(bus_data),
      .bus     (bif.slave)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_fails  = 0;
   logic [63:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- FIFO model (sole owner of FIFO inputs) ----------------
   int          cyc       = 0;
   int          pop_total = 0;
   int          pops_done = 0;
   int          push_done = 0;
   logic [31:0] push_buf[$];
   logic [31:0] fifo_q[$];
   logic [31:0] popped;

   always @(posedge clk) begin
      cyc++;
      #1;
      while (pops_done < pop_total) begin
         if (fifo_q.size() > 0) popped = fifo_q.pop_front();
         pops_done++;
      end
      while (push_done < push_buf.size()) begin
         fifo_q.push_back(push_buf[push_done]);
         push_done++;
      end
      bif.FIFO_EMPTY = (fifo_q.size() == 0);
      bif.FIFO_DATA  = (fifo_q.size() != 0) ? fifo_q[0] : 32'd0;
   end

   // ---------------- serial monitor ----------------
   int          sen_total = 0;
   int          sdo_bad   = 0;
   int          sclk_bad  = 0;
   logic [63:0] sdo_log   = 64'd0;
   logic        prev_sen  = 1'b0;
   int          pop_cyc_q[$];
   int          rise_cyc_q[$];
   int          fall_cyc_q[$];

   always @(negedge clk) begin
      if (bif.FIFO_READ === 1'b1) begin
         pop_total++;
         pop_cyc_q.push_back(cyc);
      end
      if (bif.SCLK_EN !== bif.SEN) sclk_bad++;
      if (bif.SEN === 1'b1) begin
         sen_total++;
         sdo_log = {sdo_log[62:0], bif.SDO};
         if (!prev_sen) rise_cyc_q.push_back(cyc);
         prev_sen = 1'b1;
      end else begin
         if (bif.SDO !== 1'b0) sdo_bad++;
         if (prev_sen) fall_cyc_q.push_back(cyc);
         prev_sen = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   int last_wr_cyc = 0;

   task automatic bus_wr(input logic [3:0] o, input logic [7:0] d);
      bif.BUS_ADD = {28'd0, o};
      tb_wdata    = d;
      tb_drv      = 1'b1;
      bif.BUS_WR  = 1'b1;
      last_wr_cyc = cyc;
      @(negedge clk);
      bif.BUS_WR  = 1'b0;
      tb_drv      = 1'b0;
   endtask

   task automatic bus_rd(input logic [3:0] o, output logic [7:0] d);
      bif.BUS_ADD = {28'd0, o};
      bif.BUS_RD  = 1'b1;
      @(negedge clk);
      bif.BUS_RD  = 1'b0;
      d = bus_data;
      @(negedge clk);
   endtask

   task automatic push_word(input logic [31:0] w);
      push_buf.push_back(w);
      repeat (2) @(negedge clk);
   endtask

   task automatic set_bits(input logic [15:0] n);
      bus_wr(4'd2, n[7:0]);
      bus_wr(4'd3, n[15:8]);
   endtask

   task automatic wait_idle(input string tag, input int max);
      int k = 0;
      while (bif.state_dbg != 3'd0 && k < max) begin
         @(negedge clk);
         k++;
      end
      check(tag, (k < max), 1);
   endtask

   task automatic wait_bits(input string tag, input int base, input int n, input int max);
      int k = 0;
      while ((sen_total - base) < n && k < max) begin
         @(negedge clk);
         #1;
         k++;
      end
      check(tag, (k < max), 1);
   endtask

   // ---------------- directed scenarios ----------------
   logic [7:0] rd;
   int         sen_b, pop_b, rise_b, fall_b;

   task automatic snap();
      sen_b  = sen_total;
      pop_b  = pop_total;
      rise_b = rise_cyc_q.size();
      fall_b = fall_cyc_q.size();
   endtask

   initial begin
      rst_n       = 1'b0;
      tb_drv      = 1'b0;
      tb_wdata    = 8'd0;
      bif.BUS_ADD = '0;
      bif.BUS_RD  = 1'b0;
      bif.BUS_WR  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_sen", bif.SEN, 0);
      check("rst_fifo_read", bif.FIFO_READ, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      bus_rd(4'd0, rd); check("version", rd, 8'd1);
      bus_rd(4'd1, rd); check("rst_status", rd, 8'h00);
      bus_rd(4'd2, rd); check("rst_bitcnt", rd, 8'h00);
      bus_rd(4'd4, rd); check("rst_popped", rd, 8'h00);
      bus_rd(4'd9, rd); check("unmapped_rd", rd, 8'h00);

      // One full word, MSB first
      push_word(32'hA5A5_0F0F);
      set_bits(16'd32);
      snap();
      exp_q.push_back(64'hA5A5_0F0F);
      bus_wr(4'd1, 8'h01);
      wait_idle("s1_idle", 200);
      check("s1_pop_cycle", pop_cyc_q[pop_b], last_wr_cyc + 1);
      check("s1_sen_cycle", rise_cyc_q[rise_b], last_wr_cyc + 2);
      check("s1_pops", pop_total - pop_b, 1);
      check("s1_sen_len", sen_total - sen_b, 32);
      check("s1_sen_runs", rise_cyc_q.size() - rise_b, 1);
      check("s1_sdo", {32'd0, sdo_log[31:0]}, exp_q.pop_front());
      bus_rd(4'd1, rd); check("s1_status", rd, 8'h01);
      bus_rd(4'd4, rd); check("s1_popped_lo", rd, 8'h01);
      bus_rd(4'd5, rd); check("s1_popped_hi", rd, 8'h00);

      // Two words, 40 bits; START and BIT_CNT writes while busy
      push_word(32'hFFFF_FFFF);
      push_word(32'h0000_0001);
      set_bits(16'd40);
      snap();
      exp_q.push_back(64'hFF_FFFF_FF00);
      bus_wr(4'd1, 8'h01);
      wait_bits("s2_bits_wait", sen_b, 5, 100);
      bus_wr(4'd1, 8'h01);
      bus_wr(4'd2, 8'h08);
      wait_idle("s2_idle", 200);
      check("s2_sen_len", sen_total - sen_b, 40);
      check("s2_sen_runs", rise_cyc_q.size() - rise_b, 2);
      check("s2_gap", rise_cyc_q[rise_b + 1] - fall_cyc_q[fall_b], 1);
      check("s2_sdo", {24'd0, sdo_log[39:0]}, exp_q.pop_front());
      check("s2_pops", pop_total - pop_b, 2);
      check("s2_fifo_left", fifo_q.size(), 0);
      bus_rd(4'd4, rd); check("s2_popped_lo", rd, 8'h02);
      bus_rd(4'd2, rd); check("s2_bitcnt_new", rd, 8'h08);

      // Underflow and stall, then resume
      snap();
      bus_wr(4'd1, 8'h01);
      repeat (10) @(negedge clk);
      bus_rd(4'd1, rd); check("s3_stall_status", rd, 8'h0a);
      check("s3_no_sen", sen_total - sen_b, 0);
      push_word(32'h8000_0000);
      wait_idle("s3_idle", 100);
      check("s3_sen_len", sen_total - sen_b, 8);
      check("s3_sdo", sdo_log[7:0], 8'h80);
      bus_rd(4'd1, rd); check("s3_status", rd, 8'h09);

      // Zero-length transfer
      push_word(32'hA5A5_0F0F);
      bus_wr(4'd2, 8'h00);
      snap();
      bus_wr(4'd1, 8'h01);
      bus_rd(4'd1, rd); check("s4_done", rd, 8'h01);
      wait_idle("s4_idle", 20);
      check("s4_pops", pop_total - pop_b, 0);
      check("s4_sen", sen_total - sen_b, 0);
      check("s4_fifo_kept", fifo_q.size(), 1);

      // Soft reset at bit 10
      set_bits(16'd32);
      snap();
      bus_wr(4'd1, 8'h01);
      wait_bits("s5_bits_wait", sen_b, 10, 100);
      bus_wr(4'd0, 8'h00);
      check("s5_sen_off", bif.SEN, 0);
      snap();
      repeat (5) @(negedge clk);
      check("s5_no_more_bits", sen_total - sen_b, 0);
      check("s5_no_more_pops", pop_total - pop_b, 0);
      bus_rd(4'd1, rd); check("s5_status", rd, 8'h00);
      bus_rd(4'd2, rd); check("s5_bitcnt", rd, 8'h00);
      bus_rd(4'd4, rd); check("s5_popped", rd, 8'h00);
      push_word(32'hA5A5_0F0F);
      set_bits(16'd32);
      snap();
      bus_wr(4'd1, 8'h01);
      wait_idle("s5_idle", 200);
      check("s5_sen_len", sen_total - sen_b, 32);
      check("s5_sdo", sdo_log[31:0], 32'hA5A5_0F0F);
      check("s5_pops", pop_total - pop_b, 1);

      // Asynchronous reset at bit 10
      push_word(32'h1234_5678);
      snap();
      bus_wr(4'd1, 8'h01);
      wait_bits("s6_bits_wait", sen_b, 10, 100);
      rst_n = 1'b0;
      #1;
      check("s6_sen_off", bif.SEN, 0);
      check("s6_sdo_off", bif.SDO, 0);
      check("s6_sclk_off", bif.SCLK_EN, 0);
      check("s6_fifo_read_off", bif.FIFO_READ, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus_rd(4'd1, rd); check("s6_status", rd, 8'h00);
      bus_rd(4'd2, rd); check("s6_bitcnt", rd, 8'h00);

      // CTRL bit2 shift-direction option
      push_word(32'h0000_0003);
      set_bits(16'd4);
      snap();
      bus_wr(4'd1, 8'h05);
      wait_idle("s7_idle", 100);
      check("s7_sen_len", sen_total - sen_b, 4);
`ifdef FAST_SPI_TX_LSB_FIRST_EN
      check("s7_sdo", sdo_log[3:0], 4'b1100);
      bus_rd(4'd1, rd); check("s7_status", rd, 8'h05);
`else
      check("s7_sdo", sdo_log[3:0], 4'b0000);
      bus_rd(4'd1, rd); check("s7_status", rd, 8'h01);
`endif

      check("sdo_low_when_idle", sdo_bad, 0);
      check("sclk_en_tracks_sen", sclk_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=%0d exp=finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
